rv32i_mem_port_arbiter: RTL and testbench

//  Shares one single-ported memory between the RV32I46F instruction-fetch (IF) and data-memory (DM) requesters.

---
 rtl/rv32i_mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_rv32i_mem_port_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mem_port_arbiter.sv
// Shares one single-ported RAM between instruction fetch and data memory.
// DM has priority, bounded by a fetch anti-starvation streak limit and a bus timeout.
module rv32i_mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STREAK_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_done,
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [DATA_WIDTH/8-1:0] dm_wmask,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    dm_done,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ack,
  output logic                    bus_err
);
  localparam int SW = $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_TOP = SW'(STREAK_MAX);
  localparam logic [7:0]    TMO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_DM, BUSY_IF} state_t;
  state_t state, state_nx;

  logic [SW-1:0] streak;
  logic [7:0]    tmo_cnt;
  logic          if_pend, dm_pend, grant_dm, grant_if, busy, fin_ack, fin_tmo;

  // A requester whose done is high still shows its finished request; mask it.
  always_comb begin
    if_pend  = if_req && !if_done;
    dm_pend  = dm_req && !dm_done;
    grant_dm = (state == IDLE) && dm_pend && !(if_pend && streak == STREAK_TOP);
    grant_if = (state == IDLE) && !grant_dm && if_pend;
    busy     = (state != IDLE);
    fin_ack  = busy && mem_ack;
    fin_tmo  = busy && !mem_ack && (tmo_cnt == TMO_LAST);
    state_nx = state;
    if (grant_dm)               state_nx = BUSY_DM;
    else if (grant_if)          state_nx = BUSY_IF;
    else if (fin_ack || fin_tmo) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_rdata  <= '0;
      if_done   <= 1'b0;
      dm_rdata  <= '0;
      dm_done   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wmask <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      bus_err   <= 1'b0;
      streak    <= '0;
      tmo_cnt   <= '0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      if (grant_dm) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_wmask <= dm_wmask;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        tmo_cnt   <= '0;
        if (!if_pend)                streak <= '0;
        else if (streak != STREAK_TOP) streak <= streak + SW'(1);
      end else if (grant_if) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_wmask <= '0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        tmo_cnt   <= '0;
        streak    <= '0;
      end else if (fin_ack || fin_tmo) begin
        mem_req <= 1'b0;
        bus_err <= bus_err | fin_tmo;
        if (state == BUSY_IF) begin
          if_done  <= 1'b1;
          if_rdata <= fin_ack ? mem_rdata : '0;
        end else begin
          dm_done <= 1'b1;
          // Writes leave the last read data in place; a timeout zeroes it.
          if (fin_tmo)      dm_rdata <= '0;
          else if (!mem_we) dm_rdata <= mem_rdata;
        end
      end else if (busy) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_rv32i_mem_port_arbiter.sv
// Randomized bench for the IF/DM memory port arbiter with a transaction-level model.
module tb_rv32i_mem_port_arbiter;
  localparam int AW = 32, DW = 32, MW = 4, SMAX = 4, TMO = 8;

  logic clk = 1'b0, reset = 1'b1;
  logic if_req = 1'b0, if_done, dm_req = 1'b0, dm_we = 1'b0, dm_done;
  logic [AW-1:0] if_addr = '0, dm_addr = '0, mem_addr;
  logic [DW-1:0] if_rdata, dm_rdata, dm_wdata = '0, mem_wdata, mem_rdata = '0;
  logic [MW-1:0] dm_wmask = '0, mem_wmask;
  logic mem_req, mem_we, mem_ack = 1'b0, bus_err;

  always #5 clk = ~clk;

  rv32i_mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STREAK_MAX(SMAX), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_wmask(dm_wmask), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the port, how long it has waited, what the requesters should see.
  int owner, streak, busy_cyc, lat;          // owner: 0 none, 1 DM, 2 IF
  logic exp_if_done, exp_dm_done, exp_mem_req, exp_err, exp_we;
  logic [DW-1:0] exp_if_rd, exp_dm_rd, exp_wdata;
  logic [AW-1:0] exp_addr;
  logic [MW-1:0] exp_mask;
  int p_if, p_dm, lat_min, lat_max;
  bit no_ack, junk_ack, fix_en;
  logic [DW-1:0] fix_rd;
  int grants[$];

  task automatic model_reset();
    owner = 0; streak = 0; busy_cyc = 0; lat = 0;
    exp_if_done = 0; exp_dm_done = 0; exp_mem_req = 0; exp_err = 0; exp_we = 0;
    exp_if_rd = '0; exp_dm_rd = '0; exp_wdata = '0; exp_addr = '0; exp_mask = '0;
  endtask

  task automatic model_step();
    logic ip, dp, nid, ndd;
    logic [DW-1:0] d;
    ip = if_req && !exp_if_done;
    dp = dm_req && !exp_dm_done;
    nid = 0; ndd = 0;
    if (owner == 0) begin
      if (dp && !(ip && streak == SMAX)) begin
        owner = 1;
        streak = ip ? ((streak < SMAX) ? streak + 1 : SMAX) : 0;
        exp_we = dm_we; exp_mask = dm_wmask; exp_addr = dm_addr; exp_wdata = dm_wdata;
        grants.push_back(1);
      end else if (ip) begin
        owner = 2; streak = 0;
        exp_we = 0; exp_mask = '0; exp_addr = if_addr;
        grants.push_back(2);
      end
      if (owner != 0) begin
        exp_mem_req = 1; busy_cyc = 0;
        lat = no_ack ? 1000 : $urandom_range(lat_max, lat_min);
      end
    end else if (mem_ack || busy_cyc + 1 == TMO) begin
      d = mem_ack ? mem_rdata : '0;
      if (!mem_ack) exp_err = 1;
      if (owner == 2) begin nid = 1; exp_if_rd = d; end
      else begin ndd = 1; if (!mem_ack || !exp_we) exp_dm_rd = d; end
      owner = 0; exp_mem_req = 0;
    end else busy_cyc++;
    exp_if_done = nid; exp_dm_done = ndd;
  endtask

  task automatic check_outputs();
    chk("mem_req", mem_req, exp_mem_req);
    chk("if_done", if_done, exp_if_done);
    chk("dm_done", dm_done, exp_dm_done);
    chk("done_excl", if_done & dm_done, 0);
    chk("bus_err", bus_err, exp_err);
    chk("if_rdata", if_rdata, exp_if_rd);
    chk("dm_rdata", dm_rdata, exp_dm_rd);
    if (exp_mem_req) begin
      chk("mem_addr", mem_addr, exp_addr);
      chk("mem_we", mem_we, exp_we);
      chk("mem_wmask", mem_wmask, exp_mask);
      if (owner == 1) chk("mem_wdata", mem_wdata, exp_wdata);
    end
  endtask

  task automatic new_if();
    if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic new_dm();
    dm_req = 1; dm_we = 1'($urandom_range(1, 0)); dm_wmask = 4'($urandom);
    dm_addr = $urandom; dm_wdata = $urandom;
  endtask

  // One clock: requesters and memory react, model advances, outputs checked at negedge.
  task automatic cycle();
    if (if_done) begin
      if ($urandom_range(99, 0) < p_if) new_if(); else if_req = 0;
    end else if (!if_req && $urandom_range(99, 0) < p_if) new_if();
    if (dm_done) begin
      if ($urandom_range(99, 0) < p_dm) new_dm(); else dm_req = 0;
    end else if (!dm_req && $urandom_range(99, 0) < p_dm) new_dm();
    mem_ack = 0; mem_rdata = $urandom;
    if (exp_mem_req && !no_ack && busy_cyc == lat) begin
      mem_ack = 1;
      if (fix_en) mem_rdata = fix_rd;
    end else if (!exp_mem_req && junk_ack && $urandom_range(3, 0) == 0) mem_ack = 1;
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset(input int n);
    reset = 1; if_req = 0; dm_req = 0; mem_ack = 0;
    model_reset();
    repeat (n) begin
      @(negedge clk);
      check_outputs();
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wmask", mem_wmask, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
    end
    reset = 0;
  endtask

  initial begin
    int k, run, maxrun, nif;
    p_if = 0; p_dm = 0; no_ack = 0; junk_ack = 0; lat_min = 0; lat_max = 0; fix_en = 1; fix_rd = '0;
    do_reset(2);

    // Fetch alone, ack in the first mem_req cycle
    fix_rd = 32'h0000_0013; if_req = 1; if_addr = 32'h100;
    cycle(); chk("t1_addr", mem_addr, 32'h100); chk("t1_we", mem_we, 0);
    cycle(); chk("t1_done", if_done, 1); chk("t1_rdata", if_rdata, 32'h13);
    cycle(); cycle();

    // Simultaneous requests: DM write wins, IF follows in the DM done cycle
    fix_rd = 32'hCAFE_0001;
    if_req = 1; if_addr = 32'h300;
    dm_req = 1; dm_we = 1; dm_wmask = 4'hF; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
    cycle(); chk("t2_dm_addr", mem_addr, 32'h200); chk("t2_dm_we", mem_we, 1);
    chk("t2_dm_wdata", mem_wdata, 32'hDEAD_BEEF);
    cycle(); chk("t2_dm_done", dm_done, 1); chk("t2_dm_rdata_kept", dm_rdata, 32'h0);
    cycle(); chk("t2_if_req", mem_req, 1); chk("t2_if_addr", mem_addr, 32'h300);
    cycle(); chk("t2_if_done", if_done, 1); chk("t2_if_rdata", if_rdata, 32'hCAFE_0001);
    cycle(); cycle();

    // Both requesters saturated: fetch must never wait behind more than SMAX DM grants
    fix_en = 0; p_if = 100; p_dm = 100; lat_min = 0; lat_max = 3;
    grants.delete();
    repeat (80) cycle();
    run = 0; maxrun = 0; nif = 0;
    foreach (grants[i]) begin
      if (grants[i] == 1) begin run++; if (run > maxrun) maxrun = run; end
      else begin run = 0; nif++; end
    end
    chk("t3_dm_run_bounded", maxrun <= SMAX, 1);
    chk("t3_if_served", nif > 0, 1);

    // Random mix, ack latency 0..5, stray acks while idle
    p_if = 50; p_dm = 50; lat_min = 0; lat_max = 5; junk_ack = 1;
    repeat (600) cycle();

    // Timeout on a DM read
    p_if = 0; p_dm = 0; junk_ack = 0;
    k = 0;
    while ((owner != 0 || if_req || dm_req) && k < 40) begin cycle(); k++; end
    chk("t4_drained", owner, 0);
    no_ack = 1;
    dm_req = 1; dm_we = 0; dm_wmask = '0; dm_addr = 32'h400; dm_wdata = '0;
    k = 0;
    do begin cycle(); k++; end while (!dm_done && k < 20);
    chk("t4_done_cycle", k, TMO + 1);
    chk("t4_rdata_zero", dm_rdata, 0);
    chk("t4_bus_err", bus_err, 1);
    no_ack = 0; junk_ack = 1;
    repeat (6) cycle();
    chk("t4_err_sticky", bus_err, 1);
    chk("t4_late_ack_ignored", mem_req, 0);

    // Reset in the middle of a DM transaction
    junk_ack = 0; lat_min = 5; lat_max = 5;
    dm_req = 1; dm_we = 0; dm_addr = 32'h500;
    cycle(); cycle();
    chk("t5_busy", mem_req, 1);
    do_reset(1);
    chk("t5_no_dm_done", dm_done, 0);
    chk("t5_err_cleared", bus_err, 0);
    cycle();
    fix_en = 1; fix_rd = 32'h0011_2233; lat_min = 0; lat_max = 0;
    if_req = 1; if_addr = 32'h104;
    cycle(); chk("t5_fetch_addr", mem_addr, 32'h104);
    cycle(); chk("t5_fetch_done", if_done, 1); chk("t5_fetch_rdata", if_rdata, 32'h0011_2233);
    cycle(); cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
